// File: rtl/tt_um_serial_adder.sv
// Byte-serial multi-byte adder/subtractor with accumulator for the Tiny Tapeout user pins.
// Operand bytes arrive LSB first on ui_in. The carry ripples across cycles. Each result
// byte is registered onto uo_out with a one-cycle out_valid pulse. The carry/borrow and
// signed-overflow flags update when the last byte of an operation is produced.
module tt_um_serial_adder #(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_ADD    = 2'd2
    } state_t;

    // Signed overflow of the MSB byte: same operand signs, different result sign.
    function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Carry for addition. Borrow (inverted carry) for subtraction.
    function automatic logic calc_cflag(input logic carry, input logic is_sub);
        return is_sub ? ~carry : carry;
    endfunction

    // Control-input decode.
    logic in_valid_s;
    logic sub_in_s;
    logic acc_in_s;
    logic unused_s;

    assign in_valid_s = uio_in[0];
    assign sub_in_s   = uio_in[1];
    assign acc_in_s   = uio_in[2];
    assign unused_s   = &{1'b0, uio_in[7:3]};

    // Architectural state.
    state_t                    state_r;
    logic [IDXW-1:0]           idx_r;
    logic [NBYTES-1:0][7:0]    a_r;
    logic [NBYTES-1:0][7:0]    r_r;
    logic                      c_r;
    logic                      sub_q_r;
    logic                      acc_q_r;
    logic [7:0]                uo_out_r;
    logic                      out_valid_r;
    logic                      cflag_r;
    logic                      ovf_r;
    logic                      busy_r;

    // Next-state and datapath controls.
    state_t          state_next_s;
    logic [IDXW-1:0] idx_next_s;
    logic            load_a_s;
    logic            copy_r_s;
    logic            latch_mode_s;
    logic            do_add_s;
    logic            last_s;
    logic [7:0]      opa_s;
    logic [7:0]      opb_s;
    logic            cin_s;
    logic [8:0]      sum_s;

    // Next-state logic and selection of the byte adder operands.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        load_a_s     = 1'b0;
        copy_r_s     = 1'b0;
        latch_mode_s = 1'b0;
        do_add_s     = 1'b0;
        last_s       = 1'b0;
        opa_s        = a_r[idx_r];
        opb_s        = ui_in ^ {8{sub_q_r}};
        cin_s        = c_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid_s) begin
                    latch_mode_s = 1'b1;
                    idx_next_s   = IDX_ONE;
                    if (acc_in_s) begin
                        // The accumulator becomes operand A. The first byte is B[0] and is added now.
                        copy_r_s     = 1'b1;
                        do_add_s     = 1'b1;
                        opa_s        = r_r[0];
                        opb_s        = ui_in ^ {8{sub_in_s}};
                        cin_s        = sub_in_s;
                        state_next_s = ST_ADD;
                    end else begin
                        load_a_s     = 1'b1;
                        state_next_s = ST_LOAD_A;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD_A: begin
                if (in_valid_s) begin
                    load_a_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        idx_next_s   = IDX_ZERO;
                        state_next_s = ST_ADD;
                    end else begin
                        idx_next_s = idx_r + IDX_ONE;
                    end
                end else begin
                    state_next_s = ST_LOAD_A;
                end
            end
            ST_ADD: begin
                if (in_valid_s) begin
                    do_add_s = 1'b1;
                    cin_s    = (idx_r == IDX_ZERO) ? sub_q_r : c_r;
                    if (idx_r == LAST_IDX) begin
                        last_s       = 1'b1;
                        idx_next_s   = IDX_ZERO;
                        state_next_s = ST_IDLE;
                    end else begin
                        idx_next_s = idx_r + IDX_ONE;
                    end
                end else begin
                    state_next_s = ST_ADD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                idx_next_s   = IDX_ZERO;
            end
        endcase
        sum_s = {1'b0, opa_s} + {1'b0, opb_s} + {8'd0, cin_s};
    end

    // State, operand store, accumulator, and registered outputs. All of them freeze while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= IDX_ZERO;
            a_r         <= '0;
            r_r         <= '0;
            c_r         <= 1'b0;
            sub_q_r     <= 1'b0;
            acc_q_r     <= 1'b0;
            uo_out_r    <= 8'd0;
            out_valid_r <= 1'b0;
            cflag_r     <= 1'b0;
            ovf_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else if (ena) begin
            state_r     <= state_next_s;
            idx_r       <= idx_next_s;
            busy_r      <= (state_next_s != ST_IDLE);
            out_valid_r <= do_add_s;
            if (latch_mode_s) begin
                sub_q_r <= sub_in_s;
                acc_q_r <= acc_in_s;
            end
            if (load_a_s) begin
                a_r[idx_r] <= ui_in;
            end
            if (copy_r_s) begin
                a_r <= r_r;
            end
            if (do_add_s) begin
                r_r[idx_r] <= sum_s[7:0];
                uo_out_r   <= sum_s[7:0];
                c_r        <= sum_s[8];
            end
            if (last_s) begin
                cflag_r <= calc_cflag(sum_s[8], sub_q_r);
                ovf_r   <= calc_ovf(opa_s[7], opb_s[7], sum_s[7]);
            end
        end
    end

    assign uo_out  = uo_out_r;
    assign uio_out = {ovf_r, busy_r, cflag_r, out_valid_r, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: doc/tt_um_serial_adder.md
# tt_um_serial_adder

Byte-serial, parametrised multi-byte adder/subtractor with accumulator; the next generation of the team's single-bit adder tile. It sits directly on the Tiny Tapeout user pins. Operands stream in one byte per cycle, LSB first, on `ui_in`. Result bytes stream out on `uo_out`, with the carry rippling across cycles, plus carry/borrow and signed-overflow flags.

## Interface

Parameters:
- `NBYTES`, default 4, operand width in bytes; legal range 2..8.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `ena`  in  1  design enable; when 0, all state freezes and inputs are ignored.
- `ui_in`  in  8  operand data byte.
- `uio_in`  in  8  control inputs:
  - [0] `in_valid`
  - [1] `sub`
  - [2] `acc`
  - [7:3] ignored
- `uo_out`  out  8  result byte.
- `uio_out`  out  8  status outputs:
  - [3:0] always 0
  - [4] `out_valid`
  - [5] `cflag`
  - [6] `busy`
  - [7] `ovf`
- `uio_oe`  out  8  constant 8'hF0.

## Operation

- Registers:
  - `A`, NBYTES×8 operand store.
  - `R`, NBYTES×8 accumulator.
  - Byte index `idx`, range 0..NBYTES-1.
  - Running carry `c`.
  - Latched mode bits `sub_q`, `acc_q`.
- States: IDLE, LOAD_A, ADD.
- IDLE, on `in_valid`:
  - Latch `sub`/`acc` into `sub_q`/`acc_q`. Mode bits are sampled only on the first byte of an operation.
  - If `acc`=0: store `ui_in` as A[0], set idx=1, go to LOAD_A.
  - If `acc`=1: set A:=R. Treat `ui_in` as B[0] and process it as the first ADD byte in this same cycle. Go to ADD with idx=1.
- LOAD_A, on `in_valid`:
  - Store A[idx] and increment idx.
  - After byte NBYTES-1 is stored, set idx=0 and go to ADD.
- ADD, on `in_valid`:
  - Compute `s = A[idx] + (ui_in ^ {8{sub_q}}) + c`. On byte 0, c is taken as `sub_q`.
  - Register s[7:0] to `uo_out`, and into R[idx]. Set c := s[8].
  - After byte NBYTES-1, return to IDLE.
- Flags, updated only when the last result byte is produced; held until the last byte of the next operation:
  - `cflag` = final carry when `sub_q`=0; = borrow (~final carry) when `sub_q`=1.
  - `ovf` = signed overflow of the MSB byte: the sign bits of the A MSB and the effective B MSB are equal and differ from the sign of the result MSB.
- `busy`=1 in LOAD_A and ADD, 0 in IDLE.
- In LOAD_A or ADD, cycles with `in_valid`=0 leave the state unchanged. Gaps of any length are allowed.
- Arithmetic is modulo 2^(8·NBYTES); two's-complement for signed interpretation.

## Timing

- Reset values:
  - `uo_out`=0, `out_valid`=0, `cflag`=0, `ovf`=0, `busy`=0.
  - A=0, R=0, state=IDLE, idx=0, c=0.
- Latency: an ADD byte accepted at edge t appears on `uo_out` with `out_valid`=1 after edge t (registered, 1 cycle).
- `out_valid` is a one-cycle pulse per result byte. `uo_out` holds its last value when `out_valid`=0.
- `busy` rises the cycle after the first accepted byte. It falls the cycle after the last ADD byte, which is the same cycle that last byte's `out_valid` and the updated flags appear.
- Back-to-back: a new operation's first byte may be accepted the cycle after the last ADD byte.
- `ena`=0 mid-operation: freeze everything, including a pending `out_valid`. It does not count as a gap event; the operation resumes when `ena`=1.
- `rst_n`=0 at any point, including mid-operation: all registers return to reset values at that edge. R is cleared.
- `sub`/`acc` changing mid-operation: no effect.

## Test plan

All scenarios use NBYTES=4; bytes are listed LSB first.
- Add 0x000000FF + 0x00000001:
  - Outputs 00,01,00,00.
  - `cflag`=0, `ovf`=0.
  - Each byte is 1 cycle after its input.
- 0xFFFFFFFF + 0x00000001 -> 00,00,00,00, `cflag`=1, `ovf`=0.
- Sub (`sub`=1) 0x00000005 − 0x00000007 -> FE,FF,FF,FF, `cflag`(borrow)=1, `ovf`=0.
- 0x7FFFFFFF + 0x00000001 -> 00,00,00,80, `ovf`=1, `cflag`=0.
- Accumulate:
  - After the first scenario (R=0x00000100), run `acc`=1 with B=0x00000100.
  - Outputs 00,02,00,00 with no LOAD_A phase; `busy` is high for 3 cycles after the first byte.
- Gaps, enable and reset:
  - Insert 3-cycle `in_valid` gaps and a 2-cycle `ena`=0 during ADD -> results identical to the gap-free run.
  - Assert `rst_n`=0 mid-ADD -> `busy`=0, all outputs 0.
  - Then `acc`=1 with B=0x00000005 -> 05,00,00,00.
